// File: rtl/tx_fire_sequencer.sv
// -----------------------------------------------------------------------------
// tx_fire_sequencer
//
// Drives the transmit output controller's command bus with a burst of fire
// pulses. Each pulse holds FIRE for W cycles and then IDLE until the next
// pulse start. Pulse starts are exactly P cycles apart. The burst parameters
// and the per-channel charge times are captured once, in the ARM cycle. The
// ADC trigger acknowledge is watched during every FIRE window.
//
// Ports
//   txCLK             transmit clock; all logic runs on its rising edge
//   txRSTn            synchronous active-low reset
//   iStart            level; starts a burst when sampled in IDLE
//   iAbort            level; ends any burst immediately (highest priority)
//   iNumPulses        pulses per burst (0 = no pulse, straight to DONE)
//   iPulsePeriod      start-to-start spacing in cycles (clamped to >= 2)
//   iFireWindow       FIRE cycles per pulse (clamped to 1..P-1)
//   iChargeTime1/2    charge times, latched in ARM
//   itxADCTriggerAck  ADC acknowledge level
//   otxControlComms   command: 0 = IDLE, 1 = FIRE
//   oChargeTime1/2    latched charge times
//   oBusy             high from ARM through DONE inclusive
//   oDone             one-cycle pulse on normal completion
//   oAborted          one-cycle pulse in the IDLE cycle after an abort
//   oPulseCount       pulses issued in the current or last burst
//   oAckMissed        sticky; some pulse ended its FIRE window without an ack
// -----------------------------------------------------------------------------
module tx_fire_sequencer #(
    parameter int CMD_W        = 8,
    parameter int CT_W         = 9,
    parameter int PER_W        = 24,
    parameter int NP_W         = 16,
    parameter int WIN_W        = 16,
    parameter int STOP_ON_MISS = 0
) (
    input  logic             txCLK,
    input  logic             txRSTn,
    input  logic             iStart,
    input  logic             iAbort,
    input  logic [NP_W-1:0]  iNumPulses,
    input  logic [PER_W-1:0] iPulsePeriod,
    input  logic [WIN_W-1:0] iFireWindow,
    input  logic [CT_W-1:0]  iChargeTime1,
    input  logic [CT_W-1:0]  iChargeTime2,
    input  logic             itxADCTriggerAck,
    output logic [CMD_W-1:0] otxControlComms,
    output logic [CT_W-1:0]  oChargeTime1,
    output logic [CT_W-1:0]  oChargeTime2,
    output logic             oBusy,
    output logic             oDone,
    output logic             oAborted,
    output logic [NP_W-1:0]  oPulseCount,
    output logic             oAckMissed
);

    // Common width for the period/window clamp so neither operand is truncated.
    localparam int CW = (PER_W > WIN_W) ? PER_W : WIN_W;

    localparam logic [CMD_W-1:0] CMD_IDLE = '0;
    localparam logic [CMD_W-1:0] CMD_FIRE = CMD_W'(1);
    localparam logic [PER_W-1:0] P_ONE    = PER_W'(1);
    localparam logic [NP_W-1:0]  N_ONE    = NP_W'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARM,
        S_FIRE,
        S_GAP,
        S_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [PER_W-1:0]  period_q, period_d;   // P
    logic [PER_W-1:0]  win_q, win_d;         // W, always < P so PER_W bits suffice
    logic [NP_W-1:0]   npulse_q, npulse_d;   // N
    logic [PER_W-1:0]  p_q, p_d;             // position within the current pulse
    logic [NP_W-1:0]   count_q, count_d;
    logic [CT_W-1:0]   ct1_q, ct1_d;
    logic [CT_W-1:0]   ct2_q, ct2_d;
    logic              ack_q, ack_d;         // ack seen during this pulse's FIRE
    logic              missed_q, missed_d;
    logic              aborted_q, aborted_d;
    logic [CMD_W-1:0]  cmd;

    // Clamped burst parameters, evaluated from the live inputs and used in ARM.
    logic [CW-1:0] per_c, win_c, win_lim;

    always_comb begin
        per_c = CW'(iPulsePeriod);
        if (per_c < CW'(2)) begin
            per_c = CW'(2);
        end
        win_c = CW'(iFireWindow);
        if (win_c == '0) begin
            win_c = CW'(1);
        end
        win_lim = (win_c > per_c - CW'(1)) ? per_c - CW'(1) : win_c;
    end

    always_comb begin
        state_d   = state_q;
        period_d  = period_q;
        win_d     = win_q;
        npulse_d  = npulse_q;
        p_d       = p_q;
        count_d   = count_q;
        ct1_d     = ct1_q;
        ct2_d     = ct2_q;
        ack_d     = ack_q;
        missed_d  = missed_q;
        aborted_d = 1'b0;
        cmd       = CMD_IDLE;

        if (state_q == S_FIRE || state_q == S_GAP) begin
            p_d = p_q + P_ONE;
        end

        case (state_q)
            S_IDLE: begin
                if (iStart && !iAbort) begin
                    state_d = S_ARM;
                end
            end
            S_ARM: begin
                period_d = PER_W'(per_c);
                win_d    = PER_W'(win_lim);
                npulse_d = iNumPulses;
                ct1_d    = iChargeTime1;
                ct2_d    = iChargeTime2;
                missed_d = 1'b0;
                if (iNumPulses == '0) begin
                    count_d = '0;
                    state_d = S_DONE;
                end else begin
                    // The pulse count steps on entry so it already reads 1
                    // during the first FIRE cycle.
                    count_d = N_ONE;
                    ack_d   = 1'b0;
                    p_d     = '0;
                    state_d = S_FIRE;
                end
            end
            S_FIRE: begin
                cmd   = CMD_FIRE;
                ack_d = ack_q | itxADCTriggerAck;
                if (p_q == win_q - P_ONE) begin
                    state_d = S_GAP;
                    if (!(ack_q | itxADCTriggerAck)) begin
                        missed_d = 1'b1;
                    end
                end
            end
            S_GAP: begin
                // ack_q is frozen in GAP and reflects the pulse just fired.
                if (STOP_ON_MISS != 0 && !ack_q) begin
                    state_d = S_DONE;
                end else if (p_q == period_q - P_ONE) begin
                    if (count_q == npulse_q) begin
                        state_d = S_DONE;
                    end else begin
                        count_d = count_q + N_ONE;
                        ack_d   = 1'b0;
                        p_d     = '0;
                        state_d = S_FIRE;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Abort overrides everything, leaving the visible status untouched.
        if (iAbort && state_q != S_IDLE) begin
            state_d   = S_IDLE;
            aborted_d = 1'b1;
            count_d   = count_q;
            missed_d  = missed_q;
            ct1_d     = ct1_q;
            ct2_d     = ct2_q;
        end
    end

    always_ff @(posedge txCLK) begin
        if (!txRSTn) begin
            state_q   <= S_IDLE;
            period_q  <= '0;
            win_q     <= '0;
            npulse_q  <= '0;
            p_q       <= '0;
            count_q   <= '0;
            ct1_q     <= '0;
            ct2_q     <= '0;
            ack_q     <= 1'b0;
            missed_q  <= 1'b0;
            aborted_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            period_q  <= period_d;
            win_q     <= win_d;
            npulse_q  <= npulse_d;
            p_q       <= p_d;
            count_q   <= count_d;
            ct1_q     <= ct1_d;
            ct2_q     <= ct2_d;
            ack_q     <= ack_d;
            missed_q  <= missed_d;
            aborted_q <= aborted_d;
        end
    end

    assign otxControlComms = cmd;
    assign oChargeTime1    = ct1_q;
    assign oChargeTime2    = ct2_q;
    assign oBusy           = (state_q != S_IDLE);
    assign oDone           = (state_q == S_DONE);
    assign oAborted        = aborted_q;
    assign oPulseCount     = count_q;
    assign oAckMissed      = missed_q;

endmodule

// File: tb/tb_tx_fire_sequencer.sv
// -----------------------------------------------------------------------------
// tb_tx_fire_sequencer
//
// Two instances share the clock and configuration inputs: dut0 continues after
// a missed ack, dut1 stops on the first miss. Stimulus pushes the expected
// burst summary into a per-instance queue; a negedge monitor builds the
// observed summary of each burst and compares when oDone or oAborted appears.
// -----------------------------------------------------------------------------
module tb_tx_fire_sequencer;

    logic        clk = 1'b0;
    logic        rstn;
    logic        start0, start1, abort_i, ack;
    logic [15:0] num_pulses;
    logic [23:0] period;
    logic [15:0] window;
    logic [8:0]  ct1_in, ct2_in;

    logic [7:0]  cmd0, cmd1;
    logic [8:0]  oct1_0, oct2_0, oct1_1, oct2_1;
    logic        busy0, busy1, done0, done1, abd0, abd1, miss0, miss1;
    logic [15:0] pc0, pc1;

    always #5 clk = ~clk;

    tx_fire_sequencer #(.STOP_ON_MISS(0)) dut0 (
        .txCLK(clk), .txRSTn(rstn), .iStart(start0), .iAbort(abort_i),
        .iNumPulses(num_pulses), .iPulsePeriod(period), .iFireWindow(window),
        .iChargeTime1(ct1_in), .iChargeTime2(ct2_in), .itxADCTriggerAck(ack),
        .otxControlComms(cmd0), .oChargeTime1(oct1_0), .oChargeTime2(oct2_0),
        .oBusy(busy0), .oDone(done0), .oAborted(abd0), .oPulseCount(pc0),
        .oAckMissed(miss0)
    );

    tx_fire_sequencer #(.STOP_ON_MISS(1)) dut1 (
        .txCLK(clk), .txRSTn(rstn), .iStart(start1), .iAbort(abort_i),
        .iNumPulses(num_pulses), .iPulsePeriod(period), .iFireWindow(window),
        .iChargeTime1(ct1_in), .iChargeTime2(ct2_in), .itxADCTriggerAck(ack),
        .otxControlComms(cmd1), .oChargeTime1(oct1_1), .oChargeTime2(oct2_1),
        .oBusy(busy1), .oDone(done1), .oAborted(abd1), .oPulseCount(pc1),
        .oAckMissed(miss1)
    );

    int n_checks = 0;
    int n_pass   = 0;

    function automatic void check(string name, longint act, longint exp);
        n_checks++;
        if (act == exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endfunction

    typedef struct {
        bit ab;
        int end_off;
        int pc;
        bit miss;
        int fc;
        int first;
        int sp;
        int run;
        int ct1;
        int ct2;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];

    task automatic push_exp(input int d, input bit ab, input int end_off,
                            input int pc, input bit miss, input int fc,
                            input int first, input int sp, input int run,
                            input int c1, input int c2);
        exp_t e;
        e.ab = ab; e.end_off = end_off; e.pc = pc; e.miss = miss; e.fc = fc;
        e.first = first; e.sp = sp; e.run = run; e.ct1 = c1; e.ct2 = c2;
        if (d == 0) q0.push_back(e);
        else        q1.push_back(e);
    endtask

    // ---------------------------------------------------------------- monitor
    bit          m_active[2];
    bit          m_bad[2];
    int          m_off[2], m_fc[2], m_first[2], m_second[2], m_run[2], m_maxrun[2];
    logic [7:0]  m_prev[2];
    logic [7:0]  mc[2];
    logic        mb[2], md[2], ma[2], mm[2];
    logic [15:0] mp[2];
    logic [8:0]  mt1[2], mt2[2];

    always @(negedge clk) begin
        mc[0] = cmd0;  mc[1] = cmd1;
        mb[0] = busy0; mb[1] = busy1;
        md[0] = done0; md[1] = done1;
        ma[0] = abd0;  ma[1] = abd1;
        mm[0] = miss0; mm[1] = miss1;
        mp[0] = pc0;   mp[1] = pc1;
        mt1[0] = oct1_0; mt1[1] = oct1_1;
        mt2[0] = oct2_0; mt2[1] = oct2_1;
        for (int d = 0; d < 2; d++) begin
            if (!rstn) begin
                m_active[d] = 1'b0;
            end else begin
                if (!m_active[d]) begin
                    if (mb[d]) begin
                        m_active[d] = 1'b1;
                        m_off[d] = 0; m_fc[d] = 0; m_first[d] = -1; m_second[d] = -1;
                        m_run[d] = 0; m_maxrun[d] = 0; m_bad[d] = 1'b0; m_prev[d] = '0;
                    end
                end else begin
                    m_off[d]++;
                end
                if (m_active[d]) begin
                    if (mc[d] == 8'd1) begin
                        m_fc[d]++;
                        m_run[d]++;
                        if (m_run[d] > m_maxrun[d]) m_maxrun[d] = m_run[d];
                        if (m_prev[d] != 8'd1) begin
                            if (m_first[d] < 0)       m_first[d] = m_off[d];
                            else if (m_second[d] < 0) m_second[d] = m_off[d];
                        end
                    end else begin
                        m_run[d] = 0;
                    end
                    if (mc[d] > 8'd1) m_bad[d] = 1'b1;
                    m_prev[d] = mc[d];
                    if (md[d] || ma[d]) begin
                        exp_t e;
                        int   sp;
                        bit   have;
                        have = (d == 0) ? (q0.size() > 0) : (q1.size() > 0);
                        sp = (m_second[d] >= 0) ? (m_second[d] - m_first[d]) : 0;
                        $display("burst end d%0d: off=%0d done=%0d aborted=%0d pc=%0d missed=%0d fire_cycles=%0d first=%0d spacing=%0d run=%0d",
                                 d, m_off[d], md[d], ma[d], mp[d], mm[d], m_fc[d],
                                 m_first[d], sp, m_maxrun[d]);
                        check($sformatf("d%0d_sb_has_entry", d), have, 1);
                        if (have) begin
                            e = (d == 0) ? q0.pop_front() : q1.pop_front();
                            check($sformatf("d%0d_aborted", d), ma[d], e.ab);
                            check($sformatf("d%0d_done", d), md[d], !e.ab);
                            check($sformatf("d%0d_end_offset", d), m_off[d], e.end_off);
                            check($sformatf("d%0d_pulse_count", d), mp[d], e.pc);
                            check($sformatf("d%0d_ack_missed", d), mm[d], e.miss);
                            check($sformatf("d%0d_fire_cycles", d), m_fc[d], e.fc);
                            check($sformatf("d%0d_first_fire", d), m_first[d], e.first);
                            check($sformatf("d%0d_spacing", d), sp, e.sp);
                            check($sformatf("d%0d_fire_run", d), m_maxrun[d], e.run);
                            check($sformatf("d%0d_charge1", d), mt1[d], e.ct1);
                            check($sformatf("d%0d_charge2", d), mt2[d], e.ct2);
                            check($sformatf("d%0d_cmd_range", d), m_bad[d], 0);
                        end
                        m_active[d] = 1'b0;
                    end
                end else if (md[d] || ma[d]) begin
                    check($sformatf("d%0d_unexpected_end", d), 1, 0);
                end
            end
        end
    end

    // -------------------------------------------------------------- stimulus
    bit         ack_en = 1'b1;
    int         skip_pulse = 0;
    int         fire_idx = 0;
    logic [7:0] prev_cmd0 = '0;

    // One ack cycle at the start of each dut0 FIRE window, except skip_pulse.
    task automatic wait_cycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            if (cmd0 == 8'd1 && prev_cmd0 != 8'd1) fire_idx++;
            ack = ack_en && (cmd0 == 8'd1) && (prev_cmd0 != 8'd1) && (fire_idx != skip_pulse);
            prev_cmd0 = cmd0;
        end
    endtask

    task automatic set_cfg(input int n, input int p, input int w,
                           input int c1, input int c2);
        num_pulses = 16'(n);
        period     = 24'(p);
        window     = 16'(w);
        ct1_in     = 9'(c1);
        ct2_in     = 9'(c2);
    endtask

    // Returns in the ARM cycle (offset 0).
    task automatic start_burst(input bit s0, input bit s1);
        fire_idx  = 0;
        prev_cmd0 = '0;
        start0 = s0;
        start1 = s1;
        wait_cycles(1);
        start0 = 1'b0;
        start1 = 1'b0;
    endtask

    initial begin
        rstn = 1'b0; start0 = 1'b1; start1 = 1'b1; abort_i = 1'b0; ack = 1'b1;
        set_cfg(3, 10, 4, 9'h1FF, 9'h1FF);
        wait_cycles(3);
        check("reset_cmd0", cmd0, 0);
        check("reset_cmd1", cmd1, 0);
        check("reset_busy0", busy0, 0);
        check("reset_pc0", pc0, 0);
        check("reset_ct1_0", oct1_0, 0);
        check("reset_ct2_0", oct2_0, 0);
        check("reset_flags0", {done0, abd0, miss0}, 0);
        start0 = 1'b0; start1 = 1'b0; ack = 1'b0;
        rstn = 1'b1;
        wait_cycles(2);

        // Three pulses, P=10 W=4; inputs and a stray start change mid-burst.
        set_cfg(3, 10, 4, 9'h1A5, 9'h0C3);
        push_exp(0, 0, 31, 3, 0, 12, 1, 10, 4, 9'h1A5, 9'h0C3);
        start_burst(1, 0);
        wait_cycles(2);
        set_cfg(5, 3, 9, 9'h000, 9'h1FF);
        start0 = 1'b1;
        wait_cycles(1);
        start0 = 1'b0;
        wait_cycles(31);
        check("t1_idle_after", busy0, 0);

        // Start together with abort in IDLE is ignored.
        start0 = 1'b1; abort_i = 1'b1;
        wait_cycles(1);
        start0 = 1'b0; abort_i = 1'b0;
        check("start_abort_idle_busy", busy0, 0);
        check("start_abort_idle_aborted", abd0, 0);
        wait_cycles(2);

        // N=0: ARM then DONE, no FIRE.
        set_cfg(0, 10, 4, 9'h055, 9'h100);
        push_exp(0, 0, 1, 0, 0, 0, -1, 0, 0, 9'h055, 9'h100);
        start_burst(1, 0);
        wait_cycles(4);

        // Window larger than period: clamp to W=P-1=7.
        set_cfg(2, 8, 20, 9'h011, 9'h022);
        push_exp(0, 0, 17, 2, 0, 14, 1, 8, 7, 9'h011, 9'h022);
        start_burst(1, 0);
        wait_cycles(20);

        // Abort in the first cycle of the third GAP.
        set_cfg(5, 6, 2, 9'h0AA, 9'h155);
        push_exp(0, 1, 16, 3, 0, 6, 1, 6, 2, 9'h0AA, 9'h155);
        start_burst(1, 0);
        wait_cycles(15);
        abort_i = 1'b1;
        wait_cycles(1);
        abort_i = 1'b0;
        check("abort_cmd", cmd0, 0);
        check("abort_pulse", abd0, 1);
        check("abort_no_done", done0, 0);
        check("abort_pulse_count", pc0, 3);
        wait_cycles(10);

        // Ack withheld on pulse 2: dut1 stops, dut0 carries on.
        skip_pulse = 2;
        set_cfg(4, 6, 2, 9'h0F0, 9'h00F);
        push_exp(0, 0, 25, 4, 1, 8, 1, 6, 2, 9'h0F0, 9'h00F);
        push_exp(1, 0, 10, 2, 1, 4, 1, 6, 2, 9'h0F0, 9'h00F);
        start_burst(1, 1);
        wait_cycles(9);
        check("miss_gap_missed1", miss1, 1);
        check("miss_gap_cmd1", cmd1, 0);
        check("miss_gap_busy1", busy1, 1);
        check("miss_gap_missed0", miss0, 1);
        wait_cycles(20);
        skip_pulse = 0;

        // Reset during pulse-2 FIRE, then a clean full burst.
        set_cfg(3, 10, 4, 9'h1A5, 9'h0C3);
        start_burst(1, 0);
        wait_cycles(12);
        rstn = 1'b0;
        wait_cycles(1);
        check("midrst_cmd", cmd0, 0);
        check("midrst_busy", busy0, 0);
        check("midrst_pc", pc0, 0);
        check("midrst_ct1", oct1_0, 0);
        check("midrst_ct2", oct2_0, 0);
        check("midrst_flags", {done0, abd0, miss0}, 0);
        rstn = 1'b1;
        wait_cycles(2);
        set_cfg(3, 10, 4, 9'h07E, 9'h181);
        push_exp(0, 0, 31, 3, 0, 12, 1, 10, 4, 9'h07E, 9'h181);
        start_burst(1, 0);
        wait_cycles(34);

        check("sb_drained_d0", q0.size(), 0);
        check("sb_drained_d1", q1.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/tx_fire_sequencer.md
Name: tx_fire_sequencer

Overview:
Sequencer that drives the transmit output-control block's command bus.
- Issues a burst of N fire pulses at a programmable pulse-repetition period.
- Holds the FIRE command for a programmable window per pulse, and IDLE between pulses.
- Latches the per-channel charge times and monitors the ADC trigger acknowledge.
- Sits between the host register file and the transducer output controller, in the txCLK domain.

Parameters:
CMD_W, 8, width of the control-command bus
CT_W, 9, width of each charge-time value
PER_W, 24, width of the pulse-period counter
NP_W, 16, width of the pulse-count fields
WIN_W, 16, width of the fire-window field
STOP_ON_MISS, 0, 1 = end the burst as DONE after the first pulse with a missing ADC ack

Ports:
txCLK  in  1  transmit clock; all logic on its rising edge
txRSTn  in  1  synchronous active-low reset
iStart  in  1  level, sampled in IDLE; begins a burst
iAbort  in  1  level; terminates any burst immediately
iNumPulses  in  NP_W  pulses per burst
iPulsePeriod  in  PER_W  cycles from one pulse start to the next
iFireWindow  in  WIN_W  cycles of FIRE command per pulse
iChargeTime1  in  CT_W  channel-1 charge time
iChargeTime2  in  CT_W  channel-2 charge time
itxADCTriggerAck  in  1  ADC acknowledge (level)
otxControlComms  out  CMD_W  command to output controller: 0 = IDLE, 1 = FIRE
oChargeTime1  out  CT_W  latched channel-1 charge time
oChargeTime2  out  CT_W  latched channel-2 charge time
oBusy  out  1  high from ARM through DONE inclusive
oDone  out  1  one-cycle pulse on normal completion
oAborted  out  1  one-cycle pulse when an abort is taken
oPulseCount  out  NP_W  pulses issued in the current or last burst
oAckMissed  out  1  sticky; a pulse ended without an ack

Behaviour:
- Reset (txRSTn=0 at a clock edge):
  - State goes to IDLE.
  - All outputs are 0, including otxControlComms=IDLE, oChargeTime1/2=0 and oPulseCount=0.
  - Reset mid-burst behaves identically: the command returns to IDLE on the next edge.
- State machine: IDLE, ARM, FIRE, GAP, DONE.
- IDLE:
  - Command is IDLE.
  - On iStart=1 and iAbort=0, go to ARM next cycle.
- ARM (1 cycle):
  - Command is IDLE, which clears the output controller's internal flags.
  - Latches P=max(iPulsePeriod,2), W=min(max(iFireWindow,1),P-1) and N=iNumPulses.
  - Drives oChargeTime1/2 from the charge-time inputs.
  - Clears oPulseCount and oAckMissed.
  - If N=0, go to DONE (no pulse is fired); else go to FIRE.
  - Input changes after ARM have no effect until the next burst.
- Period counter p:
  - Resets to 0 on every FIRE entry and increments every FIRE/GAP cycle.
  - FIRE holds while p<W, GAP while W<=p<P.
  - Pulse start-to-start spacing is exactly P cycles.
- FIRE:
  - Command is FIRE.
  - oPulseCount increments in the first FIRE cycle of each pulse.
  - A per-pulse ack flag sets if itxADCTriggerAck=1 in any FIRE cycle.
  - At p=W-1, go to GAP.
- GAP:
  - Command is IDLE.
  - Entering GAP with the ack flag clear sets oAckMissed. If STOP_ON_MISS=1, go directly to DONE.
  - At p=P-1: if oPulseCount=N, go to DONE; else go to FIRE.
- DONE (1 cycle):
  - Command is IDLE, oDone=1, then go to IDLE.
  - oPulseCount and oAckMissed hold until the next ARM.
- Abort:
  - iAbort=1 in any non-IDLE state gives IDLE next cycle with command IDLE and oAborted=1 for one cycle.
  - oDone is not asserted.
  - Abort has priority over every other transition, including the DONE boundary.
  - iStart=1 together with iAbort=1 in IDLE is ignored.
- iStart while busy is ignored, with no queuing.
- The command bus only ever carries 0 or 1.

Test Plan:
- N=3, P=10, W=4, ack high 1 cycle in each FIRE:
  - FIRE at cycles ARM+1..+4, +11..+14, +21..+24.
  - oDone at ARM+31; oPulseCount=3; oAckMissed=0.
- N=0, start: ARM then DONE; command never equals 1; oDone 2 cycles after start.
- W=20, P=8 (clamp): each pulse is FIRE for 7 cycles and GAP for 1; spacing is 8.
- N=5, P=6, W=2, abort asserted in the 3rd GAP:
  - Next cycle: command IDLE, oAborted pulse, no oDone, oPulseCount=3.
- STOP_ON_MISS=1, N=4, ack withheld on pulse 2:
  - oAckMissed=1 on entering pulse-2 GAP; DONE next cycle; oPulseCount=2.
- txRSTn low during FIRE of pulse 2: all outputs 0 next edge; a subsequent start runs a full burst normally.
